pipe_stage_hs: RTL and testbench

Parametrised elastic pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion. It replaces the fixed-field hold/stall stage registers between core pipeline stages (IF/ID, ID/EX, EX/MEM) with one generic block. Every payload field is carried in a single `DW`-bit bus. Backpressure propagates one stage per cycle because `in_ready_o` is driven from a register.

---
 rtl/pipe_stage_hs.sv | 122 ++++++++++++
 tb/tb_pipe_stage_hs.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_hs
//  Purpose  : Elastic pipeline stage register with a valid/ready handshake.
//             It has a main register that drives the output and a skid
//             register that absorbs one extra beat when downstream stalls.
//             It also supports flush and bubble insertion.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             flush_i          - drop all held entries at the next edge
//             in_valid_i/in_ready_o/in_data_i    - upstream handshake
//             out_valid_o/out_ready_i/out_data_o - downstream handshake
//             count_o          - entries held (0..2)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
   parameter int unsigned    DW     = 32,
   parameter logic [DW-1:0]  BUBBLE = DW'(32'h0000_0013)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o,
   output logic [1:0]    count_o
);

   // The state encoding is the occupancy, so count_o is the state itself.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_main;
   logic [DW-1:0]   w_main_nxt;
   logic [DW-1:0]   r_skid;
   logic [DW-1:0]   w_skid_nxt;
   logic            r_ready;
   logic            w_valid;
   logic            w_push;
   logic            w_pop;

   assign w_valid     = (r_state != S_EMPTY);
   assign w_push      = in_valid_i & r_ready;
   assign w_pop       = w_valid & out_ready_i;

   assign in_ready_o  = r_ready;
   assign out_valid_o = w_valid;
   assign out_data_o  = r_main;   // main holds BUBBLE whenever the stage is empty
   assign count_o     = r_state;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;

      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_state_nxt = S_ONE;
               w_main_nxt  = in_data_i;
            end
         end
         S_ONE: begin
            if (w_push && w_pop) begin
               w_main_nxt  = in_data_i;
            end else if (w_push) begin
               // Downstream stalled: park the new beat behind the head.
               w_state_nxt = S_TWO;
               w_skid_nxt  = in_data_i;
            end else if (w_pop) begin
               w_state_nxt = S_EMPTY;
               w_main_nxt  = BUBBLE;
            end
         end
         S_TWO: begin
            // r_ready is low here, so only a pop can change anything.
            if (w_pop) begin
               w_state_nxt = S_ONE;
               w_main_nxt  = r_skid;
               w_skid_nxt  = BUBBLE;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
         end
      endcase

      // Flush overrides the handshake. A concurrent push is dropped.
      if (flush_i) begin
         w_state_nxt = S_EMPTY;
         w_main_nxt  = BUBBLE;
         w_skid_nxt  = BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_main  <= BUBBLE;
         r_skid  <= BUBBLE;
         r_ready <= 1'b0;   // comes up one edge after reset is released
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
         // Registered ready: it depends on the next occupancy only, so there
         // is no combinational path from out_ready_i.
         r_ready <= (w_state_nxt != S_TWO);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_hs
//  Purpose  : Self-checking bench for pipe_stage_hs (DW = 64). A queue-based
//             reference model tracks the expected contents and ready state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

   localparam int unsigned   DW     = 64;
   localparam logic [DW-1:0] BUBBLE = 64'h0000_0000_0000_0013;

   logic          clk;
   logic          rst;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
   logic [1:0]    count_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: an ordered list of held payloads plus the expected
   // registered ready flag.
   logic [DW-1:0] m_q[$];
   logic          m_ready = 1'b0;

   pipe_stage_hs #(.DW(DW), .BUBBLE(BUBBLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .count_o     (count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and update the model from the inputs. Outputs are
   // then stable at the following negedge, where the tests sample them.
   task automatic tick();
      logic do_push;
      logic do_pop;
      @(posedge clk);
      do_push = in_valid_i & m_ready;
      do_pop  = (m_q.size() > 0) & out_ready_i;
      if (rst) begin
         m_q.delete();
         m_ready = 1'b0;
      end else if (flush_i) begin
         m_q.delete();
         m_ready = 1'b1;
      end else begin
         if (do_pop)  void'(m_q.pop_front());
         if (do_push) m_q.push_back(in_data_i);
         m_ready = (m_q.size() < 2);
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
      n_checks++; if (out_data_o !== BUBBLE) begin n_fail++; $display("FAIL reset_data: got %h expected %h", out_data_o, BUBBLE); end
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", in_ready_o); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_first_cycle: got %b expected 0", in_ready_o); end
      tick();
      n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", in_ready_o); end
   endtask

   task automatic test_stream();
      logic [DW-1:0] vals[3];
      vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
      out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = vals[i];
         tick();
         n_checks++; if (out_data_o !== vals[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data_o, vals[i]); end
         n_checks++; if (count_o !== 2'd1 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d/%b expected 1/1", i, count_o, out_valid_o); end
         n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready_o); end
      end
      in_valid_i = 1'b0;
      tick();
      n_checks++; if (count_o !== 2'd0 || out_data_o !== BUBBLE) begin n_fail++; $display("FAIL stream_drain: got %0d/%h expected 0/%h", count_o, out_data_o, BUBBLE); end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 64'hA1;
      tick();
      n_checks++; if (count_o !== 2'd1 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_first: got count %0d ready %b expected 1/1", count_o, in_ready_o); end
      in_data_i = 64'hA2;
      tick();
      in_valid_i = 1'b0;
      n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", count_o); end
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", in_ready_o); end
      n_checks++; if (out_data_o !== 64'hA1) begin n_fail++; $display("FAIL bp_head: got %h expected a1", out_data_o); end
      tick();
      n_checks++; if (count_o !== 2'd2 || out_data_o !== 64'hA1) begin n_fail++; $display("FAIL bp_hold: got %0d/%h expected 2/a1", count_o, out_data_o); end
      out_ready_i = 1'b1;
      tick();
      n_checks++; if (out_data_o !== 64'hA2 || count_o !== 2'd1) begin n_fail++; $display("FAIL bp_release: got %h/%0d expected a2/1", out_data_o, count_o); end
      n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: got %b expected 1", in_ready_o); end
      tick();
      n_checks++; if (out_data_o !== BUBBLE || count_o !== 2'd0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %h/%0d/%b expected %h/0/0", out_data_o, count_o, out_valid_o, BUBBLE); end
      idle_inputs();
   endtask

   task automatic fill_two();
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 64'hB1;
      tick();
      in_data_i   = 64'hB2;
      tick();
      in_valid_i  = 1'b0;
      n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL fill_two: got %0d expected 2", count_o); end
   endtask

   task automatic test_flush();
      fill_two();
      flush_i    = 1'b1;
      in_valid_i = 1'b1;
      in_data_i  = 64'hFF;
      tick();
      idle_inputs();
      n_checks++; if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_state: got %0d/%b expected 0/0", count_o, out_valid_o); end
      n_checks++; if (out_data_o !== BUBBLE) begin n_fail++; $display("FAIL flush_data: got %h expected %h", out_data_o, BUBBLE); end
      n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", in_ready_o); end
      out_ready_i = 1'b1;
      tick();
      n_checks++; if (out_data_o !== BUBBLE || count_o !== 2'd0) begin n_fail++; $display("FAIL flush_no_ff: got %h/%0d expected %h/0", out_data_o, count_o, BUBBLE); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      fill_two();
      rst = 1'b1;
      tick();
      n_checks++; if (count_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== BUBBLE) begin n_fail++; $display("FAIL rstmid_state: got %0d/%b/%h expected 0/0/%h", count_o, out_valid_o, out_data_o, BUBBLE); end
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0", in_ready_o); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_first: got %b expected 0", in_ready_o); end
      tick();
      n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b expected 1", in_ready_o); end
   endtask

   task automatic test_random();
      logic [DW-1:0] exp_data;
      int            pops = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid_i  = ($urandom_range(1, 0) == 1);
         out_ready_i = ($urandom_range(1, 0) == 1);
         in_data_i   = {$urandom, $urandom};
         flush_i     = ($urandom_range(99, 0) == 0);
         if (out_valid_o && out_ready_i) pops++;
         tick();
         exp_data = (m_q.size() > 0) ? m_q[0] : BUBBLE;
         n_checks++; if (count_o !== 2'(m_q.size()) || count_o > 2'd2) begin n_fail++; $display("FAIL rand_count@%0d: got %0d expected %0d", cyc, count_o, m_q.size()); end
         n_checks++; if (out_valid_o !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, out_valid_o, (m_q.size() > 0)); end
         n_checks++; if (out_data_o !== exp_data) begin n_fail++; $display("FAIL rand_data@%0d: got %h expected %h", cyc, out_data_o, exp_data); end
         n_checks++; if (in_ready_o !== m_ready) begin n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, in_ready_o, m_ready); end
      end
      n_checks++; if (pops < 1000) begin n_fail++; $display("FAIL rand_activity: got %0d pops expected at least 1000", pops); end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
